// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator control path: key codes,
// ALU operation encoding and sequencer state codes.
package calc_pkg;

  localparam int DIGITS_DEF = 4;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_CLR = 4'hE;
  localparam logic [3:0] KEY_EQ  = 4'hF;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } alu_op_e;

  localparam logic [2:0] ST_ENTER_A = 3'd0;
  localparam logic [2:0] ST_OP      = 3'd1;
  localparam logic [2:0] ST_ENTER_B = 3'd2;
  localparam logic [2:0] ST_EXEC    = 3'd3;
  localparam logic [2:0] ST_RESULT  = 3'd4;
  localparam logic [2:0] ST_ERROR   = 3'd5;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'h9);
  endfunction

  function automatic logic is_oper(input logic [3:0] code);
    return (code >= KEY_ADD) && (code <= KEY_DIV);
  endfunction

  function automatic alu_op_e key_to_op(input logic [3:0] code);
    case (code)
      KEY_ADD: return OP_ADD;
      KEY_SUB: return OP_SUB;
      KEY_MUL: return OP_MUL;
      default: return OP_DIV;
    endcase
  endfunction

endpackage

// File: rtl/bcd_entry.sv
// BCD operand register: shifts digits in from the right, tracks how many
// significant digits are held, and supports direct load and clear.
module bcd_entry
  import calc_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr,
  input  logic                         load,
  input  logic                         shift,
  input  logic [3:0]                   digit,
  input  logic [4*DIGITS-1:0]          load_val,
  input  logic [$clog2(DIGITS+1)-1:0]  load_cnt,
  output logic [4*DIGITS-1:0]          value,
  output logic [4*DIGITS-1:0]          value_next
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          lead_zero;
  logic          full;

  // A zero typed into an empty operand is not a significant digit.
  assign lead_zero = (value == '0) && (digit == 4'h0);
  assign full      = (count >= CW'(DIGITS));

  always_comb begin
    value_next = value;
    count_next = count;
    if (clr) begin
      value_next = '0;
      count_next = '0;
    end else if (load) begin
      value_next = load_val;
      count_next = load_cnt;
    end else if (shift && !lead_zero && !full) begin
      value_next = {value[W-5:0], digit};
      count_next = count + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
      count <= '0;
    end else begin
      value <= value_next;
      count <= count_next;
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Keypad calculator control FSM: builds BCD operands from key events,
// issues one ALU operation per '=' and drives the display value/error flag.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DIGITS         = DIGITS_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  output logic [4*DIGITS-1:0] alu_a,
  output logic [4*DIGITS-1:0] alu_b,
  output logic [1:0]          alu_op,
  output logic                alu_start,
  input  logic                alu_done,
  input  logic [4*DIGITS-1:0] alu_res,
  input  logic                alu_err,
  output logic [4*DIGITS-1:0] disp_value,
  output logic                disp_err,
  output logic                busy
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]    state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [W-1:0]  res_q, res_n;
  logic [W-1:0]  disp_n;
  logic [1:0]    op_n;
  logic          start_n, busy_n, err_n;

  logic          key_dig, key_opr, key_clr, key_eq;
  logic [W-1:0]  key_val;

  logic          a_clr, a_load, a_shift;
  logic [W-1:0]  a_val;
  logic [CW-1:0] a_cnt;
  logic [W-1:0]  a_next;
  logic          b_clr, b_load, b_shift;
  logic [W-1:0]  b_next;

  assign key_dig = key_valid && is_digit(key_code);
  assign key_opr = key_valid && is_oper(key_code);
  assign key_clr = key_valid && (key_code == KEY_CLR);
  assign key_eq  = key_valid && (key_code == KEY_EQ);
  assign key_val = W'(key_code);

  bcd_entry #(.DIGITS(DIGITS)) u_opa (
    .clk        (clk),
    .reset      (reset),
    .clr        (a_clr),
    .load       (a_load),
    .shift      (a_shift),
    .digit      (key_code),
    .load_val   (a_val),
    .load_cnt   (a_cnt),
    .value      (alu_a),
    .value_next (a_next)
  );

  bcd_entry #(.DIGITS(DIGITS)) u_opb (
    .clk        (clk),
    .reset      (reset),
    .clr        (b_clr),
    .load       (b_load),
    .shift      (b_shift),
    .digit      (key_code),
    .load_val   (key_val),
    .load_cnt   (CW'(1)),
    .value      (alu_b),
    .value_next (b_next)
  );

  always_comb begin
    state_n = state;
    timer_n = timer;
    res_n   = res_q;
    op_n    = alu_op;
    start_n = 1'b0;
    busy_n  = busy;
    err_n   = disp_err;
    a_clr   = 1'b0;
    a_load  = 1'b0;
    a_shift = 1'b0;
    a_val   = key_val;
    a_cnt   = CW'(1);
    b_clr   = 1'b0;
    b_load  = 1'b0;
    b_shift = 1'b0;
    // Nothing moves while disabled; an ALU done is held by the ALU until then.
    if (enable) begin
      if (key_clr) begin
        a_clr   = 1'b1;
        b_clr   = 1'b1;
        busy_n  = 1'b0;
        err_n   = 1'b0;
        timer_n = '0;
        state_n = ST_ENTER_A;
      end else begin
        case (state)
          ST_ENTER_A: begin
            if (key_dig) begin
              a_shift = 1'b1;
            end else if (key_opr) begin
              op_n    = key_to_op(key_code);
              state_n = ST_OP;
            end
          end
          ST_OP: begin
            if (key_opr) begin
              op_n = key_to_op(key_code);
            end else if (key_dig) begin
              b_load  = 1'b1;
              state_n = ST_ENTER_B;
            end
          end
          ST_ENTER_B: begin
            if (key_dig) begin
              b_shift = 1'b1;
            end else if (key_eq) begin
              start_n = 1'b1;
              busy_n  = 1'b1;
              timer_n = '0;
              state_n = ST_EXEC;
            end
          end
          ST_EXEC: begin
            if (alu_done) begin
              res_n   = alu_res;
              busy_n  = 1'b0;
              err_n   = alu_err;
              state_n = alu_err ? ST_ERROR : ST_RESULT;
            end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
              busy_n  = 1'b0;
              err_n   = 1'b1;
              state_n = ST_ERROR;
            end else begin
              timer_n = timer + TW'(1);
            end
          end
          ST_RESULT: begin
            // Operator chains the result in as the next A operand.
            if (key_opr) begin
              a_load  = 1'b1;
              a_val   = res_q;
              a_cnt   = CW'(DIGITS);
              b_clr   = 1'b1;
              op_n    = key_to_op(key_code);
              state_n = ST_OP;
            end else if (key_dig) begin
              a_load  = 1'b1;
              state_n = ST_ENTER_A;
            end
          end
          ST_ERROR: begin
            if (key_dig) begin
              a_load  = 1'b1;
              err_n   = 1'b0;
              state_n = ST_ENTER_A;
            end
          end
          default: state_n = ST_ENTER_A;
        endcase
      end
    end
  end

  always_comb begin
    case (state_n)
      ST_ENTER_A, ST_OP: disp_n = a_next;
      ST_ENTER_B:        disp_n = b_next;
      ST_RESULT:         disp_n = res_n;
      ST_ERROR:          disp_n = '0;
      default:           disp_n = disp_value;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_ENTER_A;
      timer      <= '0;
      res_q      <= '0;
      alu_op     <= OP_ADD;
      alu_start  <= 1'b0;
      busy       <= 1'b0;
      disp_err   <= 1'b0;
      disp_value <= '0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      res_q      <= res_n;
      alu_op     <= op_n;
      alu_start  <= start_n;
      busy       <= busy_n;
      disp_err   <= err_n;
      disp_value <= disp_n;
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: stimulus queues expected display,
// ALU-start and busy-length responses; a monitor pops them as the DUT responds.
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        reset, enable, key_valid;
  logic [3:0]  key_code;
  logic [15:0] alu_a, alu_b, alu_res, disp_value;
  logic [1:0]  alu_op;
  logic        alu_start, alu_done, alu_err, disp_err, busy;

  always #5 clk = ~clk;

  calc_sequencer #(.DIGITS(4), .TIMEOUT_CYCLES(255)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .alu_res    (alu_res),
    .alu_err    (alu_err),
    .disp_value (disp_value),
    .disp_err   (disp_err),
    .busy       (busy)
  );

  typedef struct { logic [15:0] v; logic e; } disp_t;
  typedef struct { logic [15:0] a; logic [15:0] b; logic [1:0] op; } start_t;

  disp_t  dq[$];
  start_t sq[$];
  int     bq[$];
  int     checks = 0;
  int     errors = 0;

  int          cfg_lat    = 3;
  logic        cfg_silent = 1'b0;
  logic [15:0] cfg_res    = '0;
  logic        cfg_err    = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ALU model: answers each start after cfg_lat cycles unless silenced.
  initial begin
    alu_done = 1'b0;
    alu_err  = 1'b0;
    alu_res  = '0;
    forever begin
      @(negedge clk);
      if (alu_start && !reset && !cfg_silent) begin
        repeat (cfg_lat - 1) @(negedge clk);
        alu_res  = cfg_res;
        alu_err  = cfg_err;
        alu_done = 1'b1;
        @(negedge clk);
        alu_done = 1'b0;
        alu_err  = 1'b0;
      end
    end
  end

  logic kseen = 1'b0;
  always @(posedge clk) kseen <= key_valid && enable;

  // Monitor: pops expectations whenever the DUT presents a response.
  initial begin
    int     run;
    disp_t  d;
    start_t s;
    run = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        run = 0;
      end else begin
        if (alu_start) begin
          if (sq.size() == 0) chk("start_unexpected", 32'(alu_start), 0);
          else begin
            s = sq.pop_front();
            chk("alu_a", 32'(alu_a), 32'(s.a));
            chk("alu_b", 32'(alu_b), 32'(s.b));
            chk("alu_op", 32'(alu_op), 32'(s.op));
          end
        end
        if (kseen || (run > 0 && !busy)) begin
          if (dq.size() == 0) chk("disp_unexpected", 32'(disp_value), 32'hFFFF_FFFF);
          else begin
            d = dq.pop_front();
            chk("disp_value", 32'(disp_value), 32'(d.v));
            chk("disp_err", 32'(disp_err), 32'(d.e));
          end
        end
        if (busy) run++;
        else if (run > 0) begin
          if (bq.size() == 0) chk("busy_unexpected", 32'(run), 0);
          else chk("busy_cycles", 32'(run), 32'(bq.pop_front()));
          run = 0;
        end
      end
    end
  end

  task automatic send(input logic [3:0] c, input logic [15:0] ev, input logic ee);
    disp_t d;
    d.v = ev;
    d.e = ee;
    dq.push_back(d);
    key_code  = c;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("busy_drop", 32'(busy), 0);
  endtask

  task automatic do_eq(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                       input logic [15:0] disp_b, input logic [15:0] rres, input logic rerr,
                       input int lat, input logic silent, input logic [15:0] fdisp,
                       input logic ferr, input int blen);
    start_t s;
    disp_t  d;
    s.a = a;
    s.b = b;
    s.op = op;
    sq.push_back(s);
    cfg_res    = rres;
    cfg_err    = rerr;
    cfg_lat    = lat;
    cfg_silent = silent;
    send(4'hF, disp_b, 1'b0);
    if (blen > 0) begin
      d.v = fdisp;
      d.e = ferr;
      dq.push_back(d);
      bq.push_back(blen);
      wait_idle(blen + 50);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_alu_a"}, 32'(alu_a), 0);
    chk({tag, "_alu_b"}, 32'(alu_b), 0);
    chk({tag, "_alu_op"}, 32'(alu_op), 0);
    chk({tag, "_alu_start"}, 32'(alu_start), 0);
    chk({tag, "_disp_value"}, 32'(disp_value), 0);
    chk({tag, "_disp_err"}, 32'(disp_err), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    key_valid = 1'b0;
    key_code = 4'h0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Reset in the middle of an operation; the late done must be ignored.
    send(4'h3, 16'h0003, 1'b0);
    send(4'hA, 16'h0003, 1'b0);
    send(4'h4, 16'h0004, 1'b0);
    do_eq(16'h0003, 16'h0004, 2'b00, 16'h0004, 16'h0077, 1'b0, 8, 1'b0, 16'h0, 1'b0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_zero("midexec_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk_zero("late_done");
    send(4'h5, 16'h0005, 1'b0);
    send(4'hE, 16'h0000, 1'b0);

    // 12 + 34 = 46
    send(4'h1, 16'h0001, 1'b0);
    send(4'h2, 16'h0012, 1'b0);
    send(4'hA, 16'h0012, 1'b0);
    send(4'h3, 16'h0003, 1'b0);
    send(4'h4, 16'h0034, 1'b0);
    do_eq(16'h0012, 16'h0034, 2'b00, 16'h0034, 16'h0046, 1'b0, 3, 1'b0, 16'h0046, 1'b0, 3);

    // Chaining: 46 - 6 = 40, then a digit starts a fresh A
    send(4'hB, 16'h0046, 1'b0);
    send(4'h6, 16'h0006, 1'b0);
    do_eq(16'h0046, 16'h0006, 2'b01, 16'h0006, 16'h0040, 1'b0, 2, 1'b0, 16'h0040, 1'b0, 2);
    send(4'h8, 16'h0008, 1'b0);
    send(4'h9, 16'h0089, 1'b0);
    send(4'hE, 16'h0000, 1'b0);

    // Digit limit and leading zeros
    send(4'h1, 16'h0001, 1'b0);
    send(4'h2, 16'h0012, 1'b0);
    send(4'h3, 16'h0123, 1'b0);
    send(4'h4, 16'h1234, 1'b0);
    send(4'h5, 16'h1234, 1'b0);
    send(4'hE, 16'h0000, 1'b0);
    send(4'h0, 16'h0000, 1'b0);
    send(4'h0, 16'h0000, 1'b0);
    send(4'h7, 16'h0007, 1'b0);
    send(4'h1, 16'h0071, 1'b0);
    send(4'h2, 16'h0712, 1'b0);
    send(4'h3, 16'h7123, 1'b0);
    send(4'h4, 16'h7123, 1'b0);
    send(4'hE, 16'h0000, 1'b0);

    // Divide by zero -> error, ignored keys, digit recovers
    send(4'h9, 16'h0009, 1'b0);
    send(4'hD, 16'h0009, 1'b0);
    send(4'h0, 16'h0000, 1'b0);
    do_eq(16'h0009, 16'h0000, 2'b11, 16'h0000, 16'h9999, 1'b1, 3, 1'b0, 16'h0000, 1'b1, 3);
    send(4'hA, 16'h0000, 1'b1);
    send(4'hF, 16'h0000, 1'b1);
    send(4'h5, 16'h0005, 1'b0);

    // Disabled key is ignored
    enable = 1'b0;
    key_code = 4'h3;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    chk("frozen_disp", 32'(disp_value), 32'h0005);
    enable = 1'b1;
    send(4'h2, 16'h0052, 1'b0);

    // Timeout: ALU never answers
    send(4'hA, 16'h0052, 1'b0);
    send(4'h2, 16'h0002, 1'b0);
    do_eq(16'h0052, 16'h0002, 2'b00, 16'h0002, 16'h0, 1'b0, 3, 1'b1, 16'h0000, 1'b1, 255);
    send(4'hE, 16'h0000, 1'b0);

    // Clear aborts a pending operation
    send(4'h1, 16'h0001, 1'b0);
    send(4'hC, 16'h0001, 1'b0);
    send(4'h3, 16'h0003, 1'b0);
    do_eq(16'h0001, 16'h0003, 2'b10, 16'h0003, 16'h0, 1'b0, 3, 1'b1, 16'h0, 1'b0, 0);
    repeat (5) @(negedge clk);
    bq.push_back(6);
    send(4'hE, 16'h0000, 1'b0);
    chk("clear_busy", 32'(busy), 0);
    send(4'h4, 16'h0004, 1'b0);

    repeat (3) @(negedge clk);
    chk("disp_queue_left", 32'(dq.size()), 0);
    chk("start_queue_left", 32'(sq.size()), 0);
    chk("busy_queue_left", 32'(bq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Central control FSM of the keypad calculator. It sits between the keypad scanner/decoder (single-cycle key events) and the ALU/display path. It assembles BCD operands from digit keys, latches the operator, and issues one ALU operation per '=' through a start/done handshake. It then routes the operand or result, plus an error flag, to the display driver.

Parameters:
DIGITS, 4, max BCD digits per operand (operand width = 4*DIGITS = 16)
TIMEOUT_CYCLES, 255, cycles to wait for alu_done before declaring error (counter width 8)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  global enable; low = freeze (key events ignored, state/timeout counter held, outputs held, alu_start forced 0)
key_valid  in  1  single-cycle pulse, key_code valid
key_code  in  4  0x0-0x9 digit, 0xA '+', 0xB '-', 0xC '*', 0xD '/', 0xE clear, 0xF '='
alu_a  out  16  operand A (BCD)
alu_b  out  16  operand B (BCD)
alu_op  out  2  00 add, 01 sub, 10 mul, 11 div
alu_start  out  1  one-cycle start pulse
alu_done  in  1  ALU result valid (pulse)
alu_res  in  16  ALU result (BCD)
alu_err  in  1  ALU error (overflow/div0), valid with alu_done
disp_value  out  16  value to display (BCD)
disp_err  out  1  display shows error
busy  out  1  high while waiting on ALU

Behaviour:
- Reset (async, active-high): state ENTER_A; alu_a/alu_b/disp_value = 0; alu_op = 00; alu_start/disp_err/busy = 0; digit count = 0; timeout = 0.
- All outputs registered. Key event sampled at rising edge k takes effect at edge k; outputs change after edge k.
- Digit entry: operand <= {operand[11:0], digit}, count+1. Leading zero (operand==0, digit 0) does not consume a digit. At count==DIGITS, further digits are ignored.
- States and transitions:
  ENTER_A: digit -> shift into A. Operator -> latch alu_op, go OP. '=' ignored. disp = A.
  OP: operator -> replaces alu_op. Digit -> B = digit, go ENTER_B. '=' ignored. disp = A.
  ENTER_B: digit -> shift into B. Operator ignored. '=' -> go EXEC, alu_start = 1 for the cycle after edge k, busy = 1. disp = B.
  EXEC: all keys except clear ignored. alu_done at edge m: capture alu_res/alu_err; alu_err=0 -> RESULT, disp = alu_res; alu_err=1 -> ERROR. busy = 0 after edge m. Timeout counter increments each enabled cycle. Reaching TIMEOUT_CYCLES without done -> ERROR.
  RESULT: operator -> A = result, B = 0, latch op, go OP (chaining). Digit -> A = digit, count = 1, go ENTER_A. '=' ignored. disp = result.
  ERROR: disp_value = 0, disp_err = 1. Digit -> clears error, A = digit, go ENTER_A. Operator and '=' are ignored.
- Clear (0xE) in any state: A = B = 0, counts = 0, disp = 0, disp_err = 0, busy = 0, go ENTER_A.
  Clear in EXEC aborts the operation. An alu_done arriving later is ignored.
- alu_a/alu_b/alu_op are stable from the alu_start cycle until done/timeout/clear.
- alu_done outside EXEC is ignored. key_valid together with alu_done in EXEC: done is processed, key is dropped (unless clear, which wins).
- enable low during EXEC: counter frozen, alu_done ignored. The ALU is required to hold done until enable returns.

Decomposition:
- Shared package calc_pkg: key code constants (KEY_ADD..KEY_EQ, KEY_CLR), alu_op encoding, state enum (ENTER_A, OP, ENTER_B, EXEC, RESULT, ERROR), DIGITS default.
- One sub-module bcd_entry: BCD shift register with digit count, leading-zero rule, load/clear controls. Instantiated twice (A and B).

Test Plan:
- Reset mid-EXEC (reset pulse between alu_start and alu_done) -> all outputs 0, state ENTER_A, a later done is ignored.
- Keys 1,2,'+',3,4,'=' with ALU model returning 0x0046 after 3 cycles -> alu_a=0x0012, alu_b=0x0034, op=00, single alu_start pulse, busy 3 cycles, disp_value=0x0046.
- Keys 1,2,3,4,5 -> disp_value=0x1234 (5th digit ignored). Keys 0,0,7 -> 0x0007 with count 1.
- Chaining: result 0x0046, then '-', 6, '=' -> alu_a=0x0046, alu_b=0x0006, op=01.
- 9,'/',0,'=' with alu_err=1 -> disp_err=1, disp_value=0. Next digit 5 -> disp_err=0, disp_value=0x0005.
- Timeout: alu_done never asserted -> ERROR exactly TIMEOUT_CYCLES enabled cycles after alu_start. A clear during EXEC returns to ENTER_A with busy=0.
